// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exec_pkg
// Brief   : Shared opcodes, FSM encoding and default parameters for exec_unit_p.
// Rev     : 1.0
// ============================================================================
package exec_pkg;

    localparam int DW_DEF     = 8;
    localparam int NREG_DEF   = 8;
    localparam int IO_TMO_DEF = 15;
    localparam int TMO_W      = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXEC    = 2'd1;
    localparam logic [1:0] ST_IO_WAIT = 2'd2;

    localparam logic [4:0] OP_JMP = 5'b00000;
    localparam logic [4:0] OP_JZ  = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_ADD = 5'b00110;
    localparam logic [4:0] OP_MVI = 5'b01000;
    localparam logic [4:0] OP_MOV = 5'b01010;
    localparam logic [4:0] OP_LDA = 5'b01100;
    localparam logic [4:0] OP_STA = 5'b01110;
    localparam logic [4:0] OP_OUT = 5'b10000;
    localparam logic [4:0] OP_IN  = 5'b10010;

    // Ops whose result is the {R[NREG-1], imm} address rather than using src.
    function automatic logic uses_page_addr(input logic [4:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_JZ) || (op == OP_JMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_regfile.sv
`default_nettype none
// ============================================================================
// Module  : exec_regfile
// Brief   : NREG x DW register file, two async read ports, one prioritised
//           write port (load > write-back > execute), synchronous reset.
// Rev     : 1.0
// ============================================================================
module exec_regfile
    import exec_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] i_waddr,
    input  logic                    i_ld_en,
    input  logic [DW-1:0]           i_ld_data,
    input  logic                    i_wb_en,
    input  logic [DW-1:0]           i_wb_data,
    input  logic                    i_ex_en,
    input  logic [DW-1:0]           i_ex_data,
    input  logic [$clog2(NREG)-1:0] i_raddr_a,
    input  logic [$clog2(NREG)-1:0] i_raddr_b,
    output logic [DW-1:0]           o_rdata_a,
    output logic [DW-1:0]           o_rdata_b
);

    logic [DW-1:0] r_regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_ld_en) begin
            r_regs[i_waddr] <= i_ld_data;
        end else if (i_wb_en) begin
            r_regs[i_waddr] <= i_wb_data;
        end else if (i_ex_en) begin
            r_regs[i_waddr] <= i_ex_data;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/exec_unit_p.sv
`default_nettype none
// ============================================================================
// Module  : exec_unit_p
// Brief   : Small execution unit: ALU/move/branch ops plus a timed IO handshake.
// Rev     : 1.0
// ============================================================================
module exec_unit_p
    import exec_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int IO_TMO = IO_TMO_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [15:0]   ir,
    output logic          busy,
    output logic          done,
    output logic          jp,
    output logic [DW+7:0] aluout,
    output logic          zf,
    output logic          cf,
    output logic          io_err,
    input  logic          mem_rd_valid,
    input  logic [DW-1:0] mem_rd_data,
    output logic [DW-1:0] mem_wr_data,
    input  logic          wbr,
    output logic          nPREQ,
    output logic          nPRD,
    output logic          nPWR,
    output logic [1:0]    IOAD,
    output logic [DW-1:0] io_dout,
    input  logic [DW-1:0] io_din,
    input  logic          io_ack
);

    localparam int              RW         = $clog2(NREG);
    localparam logic [RW-1:0]   c_top_reg  = RW'(NREG - 1);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(IO_TMO);

    logic [1:0]       r_state, w_state_nxt;
    logic [15:0]      r_ir;
    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic [DW+7:0]    r_aluout, w_aluout_nxt;
    logic             r_jp, w_jp_nxt;
    logic             r_zf, w_zf_nxt;
    logic             r_cf, w_cf_nxt;
    logic             r_done, w_done_nxt;
    logic             r_io_err, w_io_err_nxt;
    logic             r_npreq, w_npreq_nxt;
    logic             r_nprd, w_nprd_nxt;
    logic             r_npwr, w_npwr_nxt;
    logic [1:0]       r_ioad, w_ioad_nxt;
    logic [DW-1:0]    r_io_dout, w_io_dout_nxt;

    logic [4:0]       w_op;
    logic [RW-1:0]    w_dst, w_src, w_rb_addr;
    logic [7:0]       w_imm;
    logic [DW-1:0]    w_ra, w_rb;
    logic [DW:0]      w_sum, w_diff;
    logic [DW+7:0]    w_target;
    logic             w_tmo_hit;
    logic             w_ex_en;
    logic [DW-1:0]    w_ex_data;
    logic             w_unused_ir;

    assign w_op        = r_ir[15:11];
    assign w_dst       = r_ir[8+RW-1:8];
    assign w_src       = r_ir[RW-1:0];
    assign w_imm       = r_ir[7:0];
    assign w_unused_ir = ^r_ir[10:8];

    // Port B serves src for ALU/MOV and the page register for address ops.
    assign w_rb_addr = uses_page_addr(w_op) ? c_top_reg : w_src;

    exec_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_waddr   (w_dst),
        .i_ld_en   (mem_rd_valid),
        .i_ld_data (mem_rd_data),
        .i_wb_en   (wbr),
        .i_wb_data (r_aluout[DW-1:0]),
        .i_ex_en   (w_ex_en),
        .i_ex_data (w_ex_data),
        .i_raddr_a (w_dst),
        .i_raddr_b (w_rb_addr),
        .o_rdata_a (w_ra),
        .o_rdata_b (w_rb)
    );

    assign w_sum     = {1'b0, w_ra} + {1'b0, w_rb};
    assign w_diff    = {1'b0, w_ra} - {1'b0, w_rb};
    assign w_target  = {w_rb, w_imm};
    assign w_tmo_hit = (r_tmo == c_tmo_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (issue) w_state_nxt = ST_EXEC;
            ST_EXEC:    w_state_nxt = ((w_op == OP_IN) || (w_op == OP_OUT)) ? ST_IO_WAIT : ST_IDLE;
            ST_IO_WAIT: if (io_ack || w_tmo_hit) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_aluout_nxt  = r_aluout;
        w_jp_nxt      = r_jp;
        w_zf_nxt      = r_zf;
        w_cf_nxt      = r_cf;
        w_done_nxt    = 1'b0;
        w_io_err_nxt  = r_io_err;
        w_npreq_nxt   = r_npreq;
        w_nprd_nxt    = r_nprd;
        w_npwr_nxt    = r_npwr;
        w_ioad_nxt    = r_ioad;
        w_io_dout_nxt = r_io_dout;
        w_tmo_nxt     = r_tmo;
        w_ex_en       = 1'b0;
        w_ex_data     = '0;
        case (r_state)
            ST_EXEC: begin
                w_jp_nxt     = 1'b0;
                w_io_err_nxt = 1'b0;
                w_done_nxt   = 1'b1;
                case (w_op)
                    OP_ADD: begin
                        w_aluout_nxt = {8'h00, w_sum[DW-1:0]};
                        w_cf_nxt     = w_sum[DW];
                        w_zf_nxt     = (w_sum[DW-1:0] == '0);
                    end
                    OP_SUB: begin
                        w_aluout_nxt = {8'h00, w_diff[DW-1:0]};
                        w_cf_nxt     = w_diff[DW];
                        w_zf_nxt     = (w_diff[DW-1:0] == '0);
                    end
                    OP_MOV: begin
                        w_ex_en   = 1'b1;
                        w_ex_data = w_rb;
                    end
                    OP_MVI: begin
                        w_ex_en   = 1'b1;
                        w_ex_data = DW'(w_imm);
                    end
                    OP_LDA, OP_STA: w_aluout_nxt = w_target;
                    OP_JZ: begin
                        w_aluout_nxt = w_target;
                        w_jp_nxt     = (w_ra == '0);
                    end
                    OP_JMP: begin
                        w_aluout_nxt = w_target;
                        w_jp_nxt     = 1'b1;
                    end
                    OP_IN, OP_OUT: begin
                        w_done_nxt    = 1'b0;
                        w_npreq_nxt   = 1'b0;
                        w_nprd_nxt    = (w_op != OP_IN);
                        w_npwr_nxt    = (w_op != OP_OUT);
                        w_ioad_nxt    = r_ir[1:0];
                        w_io_dout_nxt = w_ra;
                        w_tmo_nxt     = '0;
                    end
                    default: ;
                endcase
            end
            ST_IO_WAIT: begin
                if (io_ack || w_tmo_hit) begin
                    w_npreq_nxt  = 1'b1;
                    w_nprd_nxt   = 1'b1;
                    w_npwr_nxt   = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_io_err_nxt = !io_ack;
                    w_tmo_nxt    = '0;
                    if (io_ack && (w_op == OP_IN)) begin
                        w_ex_en   = 1'b1;
                        w_ex_data = io_din;
                    end
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir      <= '0;
            r_tmo     <= '0;
            r_aluout  <= '0;
            r_jp      <= 1'b0;
            r_zf      <= 1'b0;
            r_cf      <= 1'b0;
            r_done    <= 1'b0;
            r_io_err  <= 1'b0;
            r_npreq   <= 1'b1;
            r_nprd    <= 1'b1;
            r_npwr    <= 1'b1;
            r_ioad    <= '0;
            r_io_dout <= '0;
        end else begin
            if ((r_state == ST_IDLE) && issue) begin
                r_ir <= ir;
            end
            r_tmo     <= w_tmo_nxt;
            r_aluout  <= w_aluout_nxt;
            r_jp      <= w_jp_nxt;
            r_zf      <= w_zf_nxt;
            r_cf      <= w_cf_nxt;
            r_done    <= w_done_nxt;
            r_io_err  <= w_io_err_nxt;
            r_npreq   <= w_npreq_nxt;
            r_nprd    <= w_nprd_nxt;
            r_npwr    <= w_npwr_nxt;
            r_ioad    <= w_ioad_nxt;
            r_io_dout <= w_io_dout_nxt;
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign jp          = r_jp;
    assign aluout      = r_aluout;
    assign zf          = r_zf;
    assign cf          = r_cf;
    assign io_err      = r_io_err;
    assign mem_wr_data = w_ra;
    assign nPREQ       = r_npreq;
    assign nPRD        = r_nprd;
    assign nPWR        = r_npwr;
    assign IOAD        = r_ioad;
    assign io_dout     = r_io_dout;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit_p.sv
`default_nettype none
// ============================================================================
// Module  : tb_exec_unit_p
// Brief   : Directed self-checking bench for exec_unit_p (8-bit and 16-bit builds).
// Rev     : 1.0
// ============================================================================
module tb_exec_unit_p;

    localparam logic [4:0] T_JMP = 5'b00000;
    localparam logic [4:0] T_JZ  = 5'b00010;
    localparam logic [4:0] T_SUB = 5'b00100;
    localparam logic [4:0] T_ADD = 5'b00110;
    localparam logic [4:0] T_MVI = 5'b01000;
    localparam logic [4:0] T_MOV = 5'b01010;
    localparam logic [4:0] T_STA = 5'b01110;
    localparam logic [4:0] T_OUT = 5'b10000;
    localparam logic [4:0] T_IN  = 5'b10010;
    localparam logic [4:0] T_NOP = 5'b11111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        issue, busy, done, jp, zf, cf, io_err, mem_rd_valid, wbr;
    logic        nPREQ, nPRD, nPWR, io_ack;
    logic [15:0] ir, aluout;
    logic [7:0]  mem_rd_data, mem_wr_data, io_dout, io_din;
    logic [1:0]  IOAD;

    logic        issue_b, busy_b, done_b, jp_b, zf_b, cf_b, io_err_b, mem_rd_valid_b, wbr_b;
    logic        nPREQ_b, nPRD_b, nPWR_b, io_ack_b;
    logic [15:0] ir_b, mem_rd_data_b, mem_wr_data_b, io_dout_b, io_din_b;
    logic [23:0] aluout_b;
    logic [1:0]  IOAD_b;

    int n_checks = 0;
    int n_fail   = 0;

    exec_unit_p #(.DW(8), .NREG(8), .IO_TMO(15)) u_dut (
        .clk(clk), .rst(rst), .issue(issue), .ir(ir), .busy(busy), .done(done),
        .jp(jp), .aluout(aluout), .zf(zf), .cf(cf), .io_err(io_err),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
        .wbr(wbr), .nPREQ(nPREQ), .nPRD(nPRD), .nPWR(nPWR), .IOAD(IOAD),
        .io_dout(io_dout), .io_din(io_din), .io_ack(io_ack)
    );

    exec_unit_p #(.DW(16), .NREG(4), .IO_TMO(15)) u_dut_b (
        .clk(clk), .rst(rst), .issue(issue_b), .ir(ir_b), .busy(busy_b), .done(done_b),
        .jp(jp_b), .aluout(aluout_b), .zf(zf_b), .cf(cf_b), .io_err(io_err_b),
        .mem_rd_valid(mem_rd_valid_b), .mem_rd_data(mem_rd_data_b), .mem_wr_data(mem_wr_data_b),
        .wbr(wbr_b), .nPREQ(nPREQ_b), .nPRD(nPRD_b), .nPWR(nPWR_b), .IOAD(IOAD_b),
        .io_dout(io_dout_b), .io_din(io_din_b), .io_ack(io_ack_b)
    );

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] d, input logic [7:0] lo);
        return {op, d, lo};
    endfunction

    // Issue one instruction from a negedge with the unit idle; returns done as
    // seen in the EXEC cycle and in the following cycle.
    task automatic run_instr(input logic [15:0] instr, output logic d_exec, output logic d_done);
        ir = instr; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        d_exec = done;
        @(negedge clk);
        d_done = done;
    endtask

    task automatic run_instr_b(input logic [15:0] instr);
        ir_b = instr; issue_b = 1'b1;
        @(negedge clk);
        issue_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_checks++; if ({busy, done, jp, zf, cf, io_err} !== 6'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b expected 000000", {busy, done, jp, zf, cf, io_err}); end
        n_checks++; if (aluout !== 16'h0000) begin n_fail++;
            $display("FAIL reset_aluout: got %h expected 0000", aluout); end
        n_checks++; if ({nPREQ, nPRD, nPWR} !== 3'b111) begin n_fail++;
            $display("FAIL reset_strobes: got %b expected 111", {nPREQ, nPRD, nPWR}); end
        n_checks++; if ({IOAD, io_dout, mem_wr_data} !== 18'h0) begin n_fail++;
            $display("FAIL reset_ioad_dout_r0: got %h expected 0", {IOAD, io_dout, mem_wr_data}); end
        n_checks++; if (aluout_b !== 24'h0 || busy_b !== 1'b0) begin n_fail++;
            $display("FAIL reset_wide: got %h/%b expected 000000/0", aluout_b, busy_b); end
    endtask

    task automatic test_add_sub;
        logic de, dd;
        run_instr(enc(T_MVI, 3'd1, 8'hF0), de, dd);
        n_checks++; if (mem_wr_data !== 8'hF0) begin n_fail++;
            $display("FAIL mvi_r1: got %h expected f0", mem_wr_data); end
        run_instr(enc(T_MVI, 3'd2, 8'h20), de, dd);
        run_instr(enc(T_ADD, 3'd1, 8'h02), de, dd);
        n_checks++; if ({de, dd} !== 2'b01) begin n_fail++;
            $display("FAIL add_done_timing: got %b expected 01", {de, dd}); end
        n_checks++; if (aluout !== 16'h0010 || cf !== 1'b1 || zf !== 1'b0) begin n_fail++;
            $display("FAIL add_result: got %h cf=%b zf=%b expected 0010 cf=1 zf=0", aluout, cf, zf); end
        n_checks++; if (mem_wr_data !== 8'hF0) begin n_fail++;
            $display("FAIL add_no_write: got %h expected f0", mem_wr_data); end
        run_instr(enc(T_SUB, 3'd2, 8'h01), de, dd);
        n_checks++; if (aluout !== 16'h0030 || cf !== 1'b1 || zf !== 1'b0) begin n_fail++;
            $display("FAIL sub_borrow: got %h cf=%b zf=%b expected 0030 cf=1 zf=0", aluout, cf, zf); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++;
            $display("FAIL done_pulse_width: got %b expected 0", done); end
    endtask

    task automatic test_jz_branch;
        logic de, dd;
        run_instr(enc(T_MVI, 3'd3, 8'h05), de, dd);
        run_instr(enc(T_SUB, 3'd3, 8'h03), de, dd);
        n_checks++; if (aluout !== 16'h0000 || zf !== 1'b1 || cf !== 1'b0) begin n_fail++;
            $display("FAIL sub_zero: got %h zf=%b cf=%b expected 0000 zf=1 cf=0", aluout, zf, cf); end
        wbr = 1'b1;
        @(negedge clk);
        wbr = 1'b0;
        n_checks++; if (mem_wr_data !== 8'h00) begin n_fail++;
            $display("FAIL wbr_r3: got %h expected 00", mem_wr_data); end
        run_instr(enc(T_MVI, 3'd7, 8'h12), de, dd);
        run_instr(enc(T_JZ, 3'd3, 8'h40), de, dd);
        n_checks++; if (jp !== 1'b1 || aluout !== 16'h1240 || zf !== 1'b1) begin n_fail++;
            $display("FAIL jz_taken: got jp=%b %h zf=%b expected jp=1 1240 zf=1", jp, aluout, zf); end
        repeat (2) @(negedge clk);
        n_checks++; if (jp !== 1'b1) begin n_fail++;
            $display("FAIL jp_hold: got %b expected 1", jp); end
        run_instr(enc(T_NOP, 3'd1, 8'h00), de, dd);
        n_checks++; if (dd !== 1'b1 || jp !== 1'b0 || aluout !== 16'h1240 || {zf, cf} !== 2'b10) begin n_fail++;
            $display("FAIL nop: got done=%b jp=%b %h zc=%b expected 1 0 1240 10", dd, jp, aluout, {zf, cf}); end
        run_instr(enc(T_JZ, 3'd1, 8'h55), de, dd);
        n_checks++; if (jp !== 1'b0 || aluout !== 16'h1255) begin n_fail++;
            $display("FAIL jz_not_taken: got jp=%b %h expected jp=0 1255", jp, aluout); end
        run_instr(enc(T_JMP, 3'd0, 8'h80), de, dd);
        n_checks++; if (jp !== 1'b1 || aluout !== 16'h1280) begin n_fail++;
            $display("FAIL jmp: got jp=%b %h expected jp=1 1280", jp, aluout); end
        run_instr(enc(T_MOV, 3'd6, 8'h07), de, dd);
        n_checks++; if (mem_wr_data !== 8'h12 || jp !== 1'b0) begin n_fail++;
            $display("FAIL mov: got %h jp=%b expected 12 jp=0", mem_wr_data, jp); end
    endtask

    task automatic test_io_in;
        int  lowcnt;
        bit  fin, bad;
        logic d_end, e_end;
        lowcnt = 0; fin = 0; bad = 0; d_end = 1'b0; e_end = 1'b1;
        ir = enc(T_IN, 3'd4, 8'h02); issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clk);
            if (nPREQ === 1'b0) begin
                lowcnt++;
                if (nPRD !== 1'b0 || nPWR !== 1'b1 || IOAD !== 2'd2 || busy !== 1'b1) bad = 1;
                if (lowcnt == 4) begin io_ack = 1'b1; io_din = 8'hA5; end
            end else if (lowcnt > 0) begin
                fin = 1; d_end = done; e_end = io_err;
            end
        end
        io_ack = 1'b0;
        n_checks++; if (!fin || lowcnt != 4) begin n_fail++;
            $display("FAIL in_low_cycles: got %0d (ended=%0d) expected 4", lowcnt, fin); end
        n_checks++; if (bad) begin n_fail++;
            $display("FAIL in_strobes: got bad strobe/IOAD/busy expected nPRD=0 nPWR=1 IOAD=2"); end
        n_checks++; if (d_end !== 1'b1 || e_end !== 1'b0 || nPRD !== 1'b1) begin n_fail++;
            $display("FAIL in_complete: got done=%b io_err=%b nPRD=%b expected 1 0 1", d_end, e_end, nPRD); end
        n_checks++; if (mem_wr_data !== 8'hA5) begin n_fail++;
            $display("FAIL in_r4: got %h expected a5", mem_wr_data); end
    endtask

    task automatic test_io_out_timeout;
        int  lowcnt;
        bit  fin, bad;
        logic d_end, e_end, de, dd;
        lowcnt = 0; fin = 0; bad = 0; d_end = 1'b0; e_end = 1'b0;
        ir = enc(T_OUT, 3'd4, 8'h01); issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clk);
            if (nPREQ === 1'b0) begin
                lowcnt++;
                if (nPWR !== 1'b0 || nPRD !== 1'b1 || IOAD !== 2'd1 || io_dout !== 8'hA5) bad = 1;
            end else if (lowcnt > 0) begin
                fin = 1; d_end = done; e_end = io_err;
            end
        end
        n_checks++; if (!fin || lowcnt != 16) begin n_fail++;
            $display("FAIL out_tmo_cycles: got %0d (ended=%0d) expected 16", lowcnt, fin); end
        n_checks++; if (bad) begin n_fail++;
            $display("FAIL out_strobes: got bad strobe/IOAD/io_dout expected nPWR=0 IOAD=1 dout=a5"); end
        n_checks++; if (d_end !== 1'b1 || e_end !== 1'b1) begin n_fail++;
            $display("FAIL out_tmo_err: got done=%b io_err=%b expected 1 1", d_end, e_end); end
        n_checks++; if (mem_wr_data !== 8'hA5) begin n_fail++;
            $display("FAIL out_r4_kept: got %h expected a5", mem_wr_data); end
        run_instr(enc(T_STA, 3'd1, 8'h00), de, dd);
        n_checks++; if (mem_wr_data !== 8'hF0 || io_err !== 1'b0) begin n_fail++;
            $display("FAIL out_r1_kept: got %h io_err=%b expected f0 0", mem_wr_data, io_err); end
    endtask

    task automatic test_issue_ignored;
        int  lowcnt;
        bit  fin;
        logic d_end, de, dd;
        lowcnt = 0; fin = 0; d_end = 1'b0;
        ir = enc(T_IN, 3'd2, 8'h03); issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clk);
            issue = 1'b0;
            if (nPREQ === 1'b0) begin
                lowcnt++;
                if (lowcnt == 2) begin ir = enc(T_MVI, 3'd0, 8'h77); issue = 1'b1; end
                if (lowcnt == 3) begin io_ack = 1'b1; io_din = 8'h5A; end
            end else if (lowcnt > 0) begin
                fin = 1; d_end = done;
            end
        end
        io_ack = 1'b0;
        n_checks++; if (!fin || lowcnt != 3 || d_end !== 1'b1) begin n_fail++;
            $display("FAIL ign_io: got low=%0d done=%b expected 3 1", lowcnt, d_end); end
        n_checks++; if (mem_wr_data !== 8'h5A) begin n_fail++;
            $display("FAIL ign_r2: got %h expected 5a", mem_wr_data); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++;
            $display("FAIL ign_no_exec: got done=%b busy=%b expected 0 0", done, busy); end
        run_instr(enc(T_STA, 3'd0, 8'h00), de, dd);
        n_checks++; if (mem_wr_data !== 8'h00) begin n_fail++;
            $display("FAIL ign_r0: got %h expected 00", mem_wr_data); end
    endtask

    task automatic test_reset_mid_io;
        logic de, dd;
        bit   saw_done;
        saw_done = 0;
        ir = enc(T_OUT, 3'd1, 8'h00); issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (nPREQ !== 1'b0 || nPWR !== 1'b0) begin n_fail++;
            $display("FAIL rst_pre_low: got %b%b expected 00", nPREQ, nPWR); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({nPREQ, nPRD, nPWR} !== 3'b111 || done !== 1'b0 || busy !== 1'b0) begin n_fail++;
            $display("FAIL rst_abort: got strobes=%b done=%b busy=%b expected 111 0 0", {nPREQ, nPRD, nPWR}, done, busy); end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1;
        end
        n_checks++; if (saw_done) begin n_fail++;
            $display("FAIL rst_no_done: got done pulse expected none"); end
        for (int k = 0; k < 8; k++) begin
            run_instr(enc(T_STA, 3'(k), 8'h00), de, dd);
            n_checks++; if (mem_wr_data !== 8'h00) begin n_fail++;
                $display("FAIL rst_reg_clear R%0d: got %h expected 00", k, mem_wr_data); end
        end
    endtask

    task automatic test_mem_write;
        logic de, dd;
        run_instr(enc(T_MVI, 3'd5, 8'h11), de, dd);
        run_instr(enc(T_MVI, 3'd6, 8'h07), de, dd);
        run_instr(enc(T_ADD, 3'd5, 8'h06), de, dd);
        n_checks++; if (aluout !== 16'h0018) begin n_fail++;
            $display("FAIL mem_add: got %h expected 0018", aluout); end
        mem_rd_valid = 1'b1; mem_rd_data = 8'h3C; wbr = 1'b1;
        @(negedge clk);
        mem_rd_valid = 1'b0; wbr = 1'b0;
        n_checks++; if (mem_wr_data !== 8'h3C) begin n_fail++;
            $display("FAIL mem_over_wbr: got %h expected 3c", mem_wr_data); end
        wbr = 1'b1;
        @(negedge clk);
        wbr = 1'b0;
        n_checks++; if (mem_wr_data !== 8'h18) begin n_fail++;
            $display("FAIL wbr_only: got %h expected 18", mem_wr_data); end
        ir = enc(T_MVI, 3'd5, 8'h99); issue = 1'b1;
        @(negedge clk);
        issue = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 8'h42;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || mem_wr_data !== 8'h42) begin n_fail++;
            $display("FAIL mem_over_exec: got done=%b %h expected 1 42", done, mem_wr_data); end
    endtask

    task automatic test_wide;
        run_instr_b(enc(T_MVI, 3'b001, 8'h11));
        mem_rd_valid_b = 1'b1; mem_rd_data_b = 16'hBE3C; wbr_b = 1'b1;
        @(negedge clk);
        mem_rd_valid_b = 1'b0; wbr_b = 1'b0;
        n_checks++; if (mem_wr_data_b !== 16'hBE3C) begin n_fail++;
            $display("FAIL wide_mem_over_wbr: got %h expected be3c", mem_wr_data_b); end
        run_instr_b(enc(T_MVI, 3'b011, 8'hAB));
        run_instr_b(enc(T_ADD, 3'b011, 8'h03));
        n_checks++; if (aluout_b !== 24'h000156 || cf_b !== 1'b0 || zf_b !== 1'b0) begin n_fail++;
            $display("FAIL wide_add: got %h cf=%b zf=%b expected 000156 0 0", aluout_b, cf_b, zf_b); end
        run_instr_b(enc(T_JMP, 3'b000, 8'h7F));
        n_checks++; if (aluout_b !== 24'h00AB7F || jp_b !== 1'b1) begin n_fail++;
            $display("FAIL wide_jmp: got %h jp=%b expected 00ab7f 1", aluout_b, jp_b); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        issue = 1'b0; ir = '0; mem_rd_valid = 1'b0; mem_rd_data = '0; wbr = 1'b0;
        io_din = '0; io_ack = 1'b0;
        issue_b = 1'b0; ir_b = '0; mem_rd_valid_b = 1'b0; mem_rd_data_b = '0; wbr_b = 1'b0;
        io_din_b = '0; io_ack_b = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_add_sub;
        test_jz_branch;
        test_io_in;
        test_io_out_timeout;
        test_issue_ignored;
        test_reset_mid_io;
        test_mem_write;
        test_wide;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_unit_p.md
EXEC_UNIT_P -- requirements
Module: exec_unit_p

Interface
REQ-001 SHALL have parameter DW, default 8, register/data width (8..16).
REQ-002 SHALL have parameter NREG, default 8, register count (power of two, 2..8); RW = clog2(NREG).
REQ-003 SHALL have parameter IO_TMO, default 15, max wait cycles for io_ack (1..255).
REQ-004 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: issue  in  1  instruction valid; ir  in  16  instruction word; busy  out  1  unit not idle; done  out  1  one-cycle completion pulse.
REQ-006 SHALL have ports: jp  out  1  branch taken; aluout  out  DW+8  result/target address; zf  out  1  zero flag; cf  out  1  carry/borrow flag; io_err  out  1  IO timeout, valid with done.
REQ-007 SHALL have ports: mem_rd_valid  in  1  memory load data strobe; mem_rd_data  in  DW  load data; mem_wr_data  out  DW  store data = R[dst]; wbr  in  1  write aluout[DW-1:0] to R[dst].
REQ-008 SHALL have ports: nPREQ, nPRD, nPWR  out  1 each  active-low IO strobes; IOAD  out  2  IO port address; io_dout  out  DW  write data; io_din  in  DW  read data; io_ack  in  1  IO completion.

Function
REQ-009 SHALL decode op = ir[15:11], dst = ir[8+RW-1:8], src = ir[RW-1:0], imm = ir[7:0].
REQ-010 SHALL implement FSM states IDLE, EXEC, IO_WAIT; issue accepted only in IDLE (ignored otherwise); busy = (state != IDLE).
REQ-011 SHALL in EXEC (one cycle after accept) execute: ADD 00110 aluout = R[dst]+R[src]; SUB 00100 aluout = R[dst]-R[src]; MOV 01010 R[dst] <= R[src]; MVI 01000 R[dst] <= zero-extended imm; LDA 01100 / STA 01110 aluout = {R[NREG-1], imm}; JZ 00010 aluout = {R[NREG-1], imm}, jp = (R[dst]==0); JMP 00000 same address, jp = 1; then pulse done, return to IDLE.
REQ-012 SHALL compute ADD/SUB at DW+1 bits: aluout = zero-extended DW-bit result, cf = carry-out (ADD) or borrow (SUB), zf = (DW-bit result == 0); other ops leave zf/cf unchanged.
REQ-013 SHALL treat undefined opcodes as NOP: done pulses, no register/flag change, jp = 0.
REQ-014 SHALL for IN 10010 / OUT 10000 in EXEC drive IOAD = ir[1:0], nPREQ = 0, and nPRD = 0 (IN) or nPWR = 0 (OUT), io_dout = R[dst], then enter IO_WAIT.
REQ-015 SHALL hold strobes in IO_WAIT until io_ack = 1; on ack: IN writes io_din to R[dst], strobes return high, done pulses, io_err = 0, to IDLE.
REQ-016 SHALL, if io_ack is absent for IO_TMO cycles in IO_WAIT, release strobes, pulse done with io_err = 1, no register write, to IDLE.
REQ-017 SHALL hold nPREQ/nPRD/nPWR = 1 outside the IO handshake; io_ack outside IO_WAIT ignored.
REQ-018 SHALL write R[dst] with mem_rd_data on mem_rd_valid and with aluout[DW-1:0] on wbr, in any state; priority mem_rd_valid > wbr > EXEC/IO write to the same cycle.
REQ-019 SHALL hold jp from EXEC until next accepted instruction; jp = 0 for non-branch ops.
REQ-020 SHALL register all outputs (no combinational path input -> output) except mem_wr_data = R[dst].

Reset
REQ-021 SHALL on rst: state IDLE, all R[i] = 0, aluout = 0, jp = 0, zf = 0, cf = 0, done = 0, io_err = 0, nPREQ = nPRD = nPWR = 1, IOAD = 0, io_dout = 0, timeout counter = 0.
REQ-022 SHALL on rst in IO_WAIT abort the transaction immediately with no done pulse and no register write.

Structure
REQ-023 SHALL place opcode constants, FSM state encoding and default parameters in shared package exec_pkg.
REQ-024 SHALL use one sub-module exec_regfile (NREG x DW, two read ports, one prioritised write port, sync reset).

Verification
REQ-025 SHALL cover: MVI R1,0xF0; MVI R2,0x20; ADD R1,R2 -> aluout = 0x0010, cf = 1, zf = 0, done 1 cycle after issue.
REQ-026 SHALL cover: MVI R3,5; SUB R3,R3 -> aluout = 0, zf = 1, cf = 0; then JZ R3 imm 0x40 with R7 = 0x12 -> jp = 1, aluout = 0x1240.
REQ-027 SHALL cover: IN port 2 to R4, io_ack after 3 cycles with io_din = 0xA5 -> nPREQ/nPRD low 4 cycles, IOAD = 2, R4 = 0xA5, io_err = 0.
REQ-028 SHALL cover: OUT port 1 no ack, IO_TMO = 15 -> strobes low 16 cycles, done with io_err = 1, registers unchanged.
REQ-029 SHALL cover: issue during IO_WAIT ignored; rst asserted mid IO_WAIT -> strobes high next cycle, no done, all registers 0.
REQ-030 SHALL cover: mem_rd_valid (0x3C) and wbr same cycle to R5 -> R5 = 0x3C; repeated with DW = 16, NREG = 4.
